// File: rtl/i2c_spi_wb_bridge_pkg.sv
// Shared types and constants for the I2C-master to simple_spi Wishbone bridge.
// Holds the FSM/response enums, SPI register indices and STATUS bit positions.
package i2c_spi_wb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_RESP = 2'd2,
      ST_REL  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RSP_ACK = 2'd0,
      RSP_ERR = 2'd1,
      RSP_RTY = 2'd2
   } resp_e;

   localparam logic [1:0] SPI_SPCR = 2'd0;
   localparam logic [1:0] SPI_SPSR = 2'd1;
   localparam logic [1:0] SPI_SPDR = 2'd2;
   localparam logic [1:0] SPI_SPER = 2'd3;

   localparam int STAT_IRQ_BIT = 0;
   localparam int STAT_TO_BIT  = 1;
   localparam int STAT_CNT_LSB = 4;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? 4'hF : v + 4'h1;
   endfunction

endpackage

// File: rtl/i2c_spi_wb_bridge_if.sv
// Wishbone bundles used by the bridge: 8-bit-address upstream bus from the
// I2C master and 2-bit-address downstream bus to the simple_spi registers.
interface i2c_wbs_if;
   logic [7:0] adr;
   logic [7:0] wdat;
   logic [7:0] rdat;
   logic [3:0] sel;
   logic       we;
   logic       cyc;
   logic       stb;
   logic       ack;
   logic       err;
   logic       rty;

   modport master (output adr, wdat, sel, we, cyc, stb, input rdat, ack, err, rty);
   modport slave  (input adr, wdat, sel, we, cyc, stb, output rdat, ack, err, rty);
endinterface

interface spi_wbm_if;
   logic [1:0] adr;
   logic [7:0] wdat;
   logic [7:0] rdat;
   logic       we;
   logic       cyc;
   logic       stb;
   logic       ack;

   modport master (output adr, wdat, we, cyc, stb, input rdat, ack);
   modport slave  (input adr, wdat, we, cyc, stb, output rdat, ack);
endinterface

// File: rtl/i2c_spi_wb_bridge_timeout_ctr.sv
// Downstream wait counter: cleared on load, counts while enabled, and flags
// expiry once LIMIT cycles have been spent waiting.
module bridge_timeout_ctr
   import i2c_spi_wb_bridge_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_r;

   // Wait-cycle counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= '0;
      end else if (en) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = (count_r == CW'(LIMIT - 1));

endmodule

// File: rtl/i2c_spi_wb_bridge.sv
// Wishbone bridge from the I2C master to the simple_spi register slave, with a
// local STATUS register (sticky SPI interrupt, timeout flag and timeout count).
module i2c_spi_wb_bridge
   import i2c_spi_wb_bridge_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 255,
   parameter logic [7:0] SPI_BASE       = 8'h00,
   parameter logic [7:0] STAT_ADDR      = 8'h10
) (
   input  logic      wb_clk_i,
   input  logic      wb_rst_i,
   i2c_wbs_if.slave  wbs,
   spi_wbm_if.master wbm,
   input  logic      spi_inta_i,
   output logic      irq_o
);
   state_e     state_r, state_s;
   resp_e      resp_s;
   logic       accept_s, resp_go_s, fwd_start_s, fwd_stop_s;
   logic       timeout_hit_s, rd_cap_s, stat_rd_s, stat_wr_s, to_expire_s;
   logic       hit_spi_s, hit_stat_s;
   logic [7:0] clr_s, status_s, status_r, rdat_r;
   logic       ack_r, err_r, rty_r, irq_r;
   logic       wbm_cyc_r, wbm_stb_r, wbm_we_r;
   logic [1:0] wbm_adr_r;
   logic [7:0] wbm_dat_r;

   assign hit_spi_s  = (wbs.adr[7:2] == SPI_BASE[7:2]);
   assign hit_stat_s = (wbs.adr == STAT_ADDR);

   bridge_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .load   (fwd_start_s),
      .en     (state_r == ST_FWD),
      .expire (to_expire_s)
   );

   // Next-state and per-cycle control decisions.
   always_comb begin
      state_s       = state_r;
      resp_s        = RSP_ACK;
      accept_s      = 1'b0;
      resp_go_s     = 1'b0;
      fwd_start_s   = 1'b0;
      fwd_stop_s    = 1'b0;
      timeout_hit_s = 1'b0;
      rd_cap_s      = 1'b0;
      stat_rd_s     = 1'b0;
      stat_wr_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (wbs.cyc && wbs.stb) begin
               accept_s = 1'b1;
               if (!wbs.sel[0]) begin
                  state_s   = ST_RESP;
                  resp_go_s = 1'b1;
                  resp_s    = RSP_ERR;
               end else if (hit_spi_s) begin
                  state_s     = ST_FWD;
                  fwd_start_s = 1'b1;
               end else if (hit_stat_s) begin
                  state_s   = ST_RESP;
                  resp_go_s = 1'b1;
                  resp_s    = RSP_ACK;
                  stat_rd_s = !wbs.we;
                  stat_wr_s = wbs.we;
               end else begin
                  state_s   = ST_RESP;
                  resp_go_s = 1'b1;
                  resp_s    = RSP_ERR;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FWD: begin
            // Upstream abandon beats ack, and ack beats a simultaneous expiry.
            if (!wbs.cyc) begin
               state_s    = ST_IDLE;
               fwd_stop_s = 1'b1;
            end else if (wbm.ack) begin
               state_s    = ST_RESP;
               resp_go_s  = 1'b1;
               resp_s     = RSP_ACK;
               fwd_stop_s = 1'b1;
               rd_cap_s   = !wbm_we_r;
            end else if (to_expire_s) begin
               state_s       = ST_RESP;
               resp_go_s     = 1'b1;
               resp_s        = RSP_RTY;
               fwd_stop_s    = 1'b1;
               timeout_hit_s = 1'b1;
            end else begin
               state_s = ST_FWD;
            end
         end
         ST_RESP: begin
            state_s = ST_REL;
         end
         ST_REL: begin
            if (!wbs.stb || !wbs.cyc) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_REL;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Sets are applied after the W1C mask so a coincident set survives.
   assign clr_s       = stat_wr_s ? wbs.wdat : 8'h00;
   assign status_s[0] = spi_inta_i | (status_r[STAT_IRQ_BIT] & ~clr_s[0]);
   assign status_s[1] = timeout_hit_s | (status_r[STAT_TO_BIT] & ~clr_s[1]);
   assign status_s[3:2] = 2'b00;
   assign status_s[7:4] = timeout_hit_s ? sat_inc4(status_r[STAT_CNT_LSB +: 4])
                                        : (status_r[STAT_CNT_LSB +: 4] & ~clr_s[7:4]);

   // FSM state, upstream termination/data and STATUS registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r  <= ST_IDLE;
         ack_r    <= 1'b0;
         err_r    <= 1'b0;
         rty_r    <= 1'b0;
         rdat_r   <= 8'h00;
         status_r <= 8'h00;
         irq_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         ack_r    <= resp_go_s && (resp_s == RSP_ACK);
         err_r    <= resp_go_s && (resp_s == RSP_ERR);
         rty_r    <= resp_go_s && (resp_s == RSP_RTY);
         status_r <= status_s;
         irq_r    <= status_r[STAT_IRQ_BIT];
         if (accept_s) begin
            rdat_r <= stat_rd_s ? status_r : 8'h00;
         end else if (rd_cap_s) begin
            rdat_r <= wbm.rdat;
         end else begin
            rdat_r <= rdat_r;
         end
      end
   end

   // Downstream request registers, loaded on forward and cleared on stop.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || fwd_stop_s) begin
         wbm_cyc_r <= 1'b0;
         wbm_stb_r <= 1'b0;
         wbm_we_r  <= 1'b0;
         wbm_adr_r <= 2'd0;
         wbm_dat_r <= 8'h00;
      end else if (fwd_start_s) begin
         wbm_cyc_r <= 1'b1;
         wbm_stb_r <= 1'b1;
         wbm_we_r  <= wbs.we;
         wbm_adr_r <= wbs.adr[1:0] - SPI_BASE[1:0];
         wbm_dat_r <= wbs.wdat;
      end else begin
         wbm_cyc_r <= wbm_cyc_r;
         wbm_stb_r <= wbm_stb_r;
         wbm_we_r  <= wbm_we_r;
         wbm_adr_r <= wbm_adr_r;
         wbm_dat_r <= wbm_dat_r;
      end
   end

   assign wbs.ack  = ack_r;
   assign wbs.err  = err_r;
   assign wbs.rty  = rty_r;
   assign wbs.rdat = rdat_r;
   assign wbm.cyc  = wbm_cyc_r;
   assign wbm.stb  = wbm_stb_r;
   assign wbm.we   = wbm_we_r;
   assign wbm.adr  = wbm_adr_r;
   assign wbm.wdat = wbm_dat_r;
   assign irq_o    = irq_r;

endmodule
